// File: rtl/video_pkg.sv
// Shared types and constants for the video coordinate tagging path.
// Coordinate width, default raster size, FSM state and pixel type.
package video_pkg;

  localparam int COORD_W         = 11;
  localparam int H_ACTIVE_DEF    = 1280;
  localparam int V_ACTIVE_DEF    = 720;
  localparam int COLOR_WIDTH_DEF = 8;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t COORD_MAX = '1;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  typedef logic [3*COLOR_WIDTH_DEF-1:0] pixel_t;

  // Increment that sticks at the top of the coordinate range.
  function automatic coord_t sat_inc(coord_t v);
    return (v == COORD_MAX) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/video_coord_tagger_if.sv
// AXI4-Stream video bundle: pixel, sideband and valid/ready.
// master drives the beat, slave returns tready.
interface video_coord_tagger_if #(
  parameter int COLOR_WIDTH = 8
);

  logic [3*COLOR_WIDTH-1:0] tdata;
  logic                     tlast;
  logic                     tuser;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata,
    output tlast,
    output tuser,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tuser,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/video_coord_tagger_axis_skid_buffer.sv
// Two-entry skid buffer: registered output plus one skid slot.
// Ports: clk/reset, in_* (sink side), out_* (source side).
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             push;
  logic             load;

  assign push = in_valid && in_ready;
  assign load = !out_valid || out_ready;

  // in_ready is a register: it falls the cycle after the skid
  // slot fills, so one beat can still land while the output
  // register is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else if (load) begin
      in_ready <= 1'b1;
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= in_data;
        end
      end
    end else if (push) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end else begin
      in_ready <= !skid_valid;
    end
  end

endmodule

// File: rtl/video_coord_tagger.sv
// Tags accepted video beats with X/Y, flags malformed frames.
// Ports: clk/reset, video_in/video_out streams, X/Y, errors, frame_count.
module video_coord_tagger
  import video_pkg::*;
#(
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  video_coord_tagger_if.slave    video_in,
  video_coord_tagger_if.master   video_out,
  output logic [COORD_W-1:0]     video_out_X,
  output logic [COORD_W-1:0]     video_out_Y,
  output logic                   err_early_eol,
  output logic                   err_late_eol,
  output logic                   err_sof,
  output logic [15:0]            frame_count
);

  localparam int PIX_W = 3 * COLOR_WIDTH;
  localparam int PAY_W = PIX_W + 2 + 2 * COORD_W;

  localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
  localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

  state_t state;
  state_t state_n;
  coord_t x;
  coord_t y;
  coord_t x_n;
  coord_t y_n;
  coord_t tag_x;
  coord_t tag_y;

  logic accept;
  logic fwd;
  logic sof;
  logic early;
  logic late;
  logic frame_done;
  logic in_ready;
  logic out_valid;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;

  assign accept          = video_in.tvalid && in_ready;
  assign video_in.tready = in_ready;

  // tuser always restarts the raster at (0,0); tlast handling
  // then runs on the restarted coordinates.
  always_comb begin
    fwd        = (state == ACTIVE) || video_in.tuser;
    sof        = (state == ACTIVE) && video_in.tuser;
    tag_x      = video_in.tuser ? '0 : x;
    tag_y      = video_in.tuser ? '0 : y;
    early      = 1'b0;
    late       = 1'b0;
    frame_done = 1'b0;
    x_n        = x;
    y_n        = y;
    state_n    = state;
    if (fwd) begin
      state_n = ACTIVE;
      if (video_in.tlast) begin
        early = tag_x < X_LAST;
        x_n   = '0;
        if (tag_y == Y_LAST) begin
          frame_done = 1'b1;
          y_n        = '0;
          state_n    = WAIT_SOF;
        end else begin
          y_n = sat_inc(tag_y);
        end
      end else begin
        late = tag_x == X_LAST;
        x_n  = sat_inc(tag_x);
        y_n  = tag_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_SOF;
      x             <= '0;
      y             <= '0;
      frame_count   <= '0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_sof       <= 1'b0;
    end else begin
      err_early_eol <= accept && early;
      err_late_eol  <= accept && late;
      err_sof       <= accept && sof;
      if (accept) begin
        state <= state_n;
        x     <= x_n;
        y     <= y_n;
        if (frame_done) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  assign in_pay = {
    video_in.tdata,
    video_in.tlast,
    video_in.tuser,
    tag_x,
    tag_y
  };

  axis_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_pay),
    .in_valid  (video_in.tvalid && fwd),
    .in_ready  (in_ready),
    .out_data  (out_pay),
    .out_valid (out_valid),
    .out_ready (video_out.tready)
  );

  assign video_out.tvalid = out_valid;

  assign {
    video_out.tdata,
    video_out.tlast,
    video_out.tuser,
    video_out_X,
    video_out_Y
  } = out_pay;

endmodule

// File: tb/tb_video_coord_tagger.sv
// Bench for video_coord_tagger: directed frames plus random traffic
// checked against a raster-position reference model.
module tb_video_coord_tagger;

  localparam int CW = 8;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int PW = 3 * CW;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  video_coord_tagger_if #(.COLOR_WIDTH(CW)) vin ();
  video_coord_tagger_if #(.COLOR_WIDTH(CW)) vout ();

  logic [10:0] ox;
  logic [10:0] oy;
  logic        e_early;
  logic        e_late;
  logic        e_sof;
  logic [15:0] fc;

  video_coord_tagger #(
    .COLOR_WIDTH (CW),
    .H_ACTIVE    (H),
    .V_ACTIVE    (V)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .video_in      (vin),
    .video_out     (vout),
    .video_out_X   (ox),
    .video_out_Y   (oy),
    .err_early_eol (e_early),
    .err_late_eol  (e_late),
    .err_sof       (e_sof),
    .frame_count   (fc)
  );

  typedef struct {
    logic [PW-1:0] d;
    logic          l;
    logic          u;
    int            x;
    int            y;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t expq[$];

  bit m_in_frame = 0;
  int m_col = 0;
  int m_line = 0;
  int m_fc = 0;
  bit m_early = 0;
  bit m_late = 0;
  bit m_sof = 0;

  int n_early = 0;
  int n_late = 0;
  int n_sof = 0;
  int n_out = 0;
  int n_acc = 0;

  bit mon_on = 0;
  int rdy_mode = 0;
  bit prev_stall = 0;
  logic [48:0] prev_snap;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] snap();
    return {vout.tvalid, vout.tdata, vout.tlast, vout.tuser, ox, oy};
  endfunction

  // Reference: where the beat sits in the raster, by the rules.
  task automatic model_accept(logic [PW-1:0] d, logic l, logic u);
    m_early = 0;
    m_late  = 0;
    m_sof   = 0;
    if (!m_in_frame && !u) return;
    m_sof = u && m_in_frame;
    if (u) begin
      m_col  = 0;
      m_line = 0;
    end
    expq.push_back('{d, l, u, m_col, m_line});
    m_in_frame = 1;
    if (l) begin
      m_early = (m_col < H - 1);
      m_col   = 0;
      if (m_line == V - 1) begin
        m_fc       = (m_fc + 1) % 65536;
        m_line     = 0;
        m_in_frame = 0;
      end else begin
        m_line = (m_line + 1 > 2047) ? 2047 : m_line + 1;
      end
    end else begin
      m_late = (m_col == H - 1);
      m_col  = (m_col + 1 > 2047) ? 2047 : m_col + 1;
    end
  endtask

  initial begin
    vout.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       vout.tready = 1'b1;
        1:       vout.tready = 1'($urandom_range(1, 0));
        default: vout.tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("err_early_eol", e_early, m_early);
      chk("err_late_eol", e_late, m_late);
      chk("err_sof", e_sof, m_sof);
      chk("frame_count", fc, m_fc);
      if (e_early) n_early++;
      if (e_late) n_late++;
      if (e_sof) n_sof++;
      if (reset) begin
        expq.delete();
        m_in_frame = 0;
        m_col = 0;
        m_line = 0;
        m_fc = 0;
        m_early = 0;
        m_late = 0;
        m_sof = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) chk("hold_stable", snap(), prev_snap);
        if (vout.tvalid && vout.tready) begin
          n_out++;
          chk("beat_expected", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            beat_t e;
            e = expq.pop_front();
            chk("tdata", vout.tdata, e.d);
            chk("tlast", vout.tlast, e.l);
            chk("tuser", vout.tuser, e.u);
            chk("x", ox, 64'(e.x));
            chk("y", oy, 64'(e.y));
          end
        end
        prev_stall = vout.tvalid && !vout.tready;
        prev_snap  = snap();
        if (vin.tvalid && vin.tready) begin
          n_acc++;
          model_accept(vin.tdata, vin.tlast, vin.tuser);
        end else begin
          m_early = 0;
          m_late  = 0;
          m_sof   = 0;
        end
      end
    end
  end

  task automatic send(logic [PW-1:0] d, logic l, logic u);
    int k = 0;
    vin.tdata  = d;
    vin.tlast  = l;
    vin.tuser  = u;
    vin.tvalid = 1'b1;
    @(negedge clk);
    while (!vin.tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("send_timeout", (k < 200) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    vin.tvalid = 1'b0;
  endtask

  task automatic idle(int n);
    vin.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(bit gaps);
    for (int l = 0; l < V; l++) begin
      for (int c = 0; c < H; c++) begin
        if (gaps && ($urandom_range(2, 0) == 0)) idle(1);
        send(PW'($urandom), c == H - 1, (l == 0) && (c == 0));
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((expq.size() != 0 || vout.tvalid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", (k < 500) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b_out;
    int b_e;
    int b_l;
    int b_s;
    int a0;
    vin.tvalid = 1'b0;
    vin.tdata  = '0;
    vin.tlast  = 1'b0;
    vin.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1;
    @(negedge clk);
    chk("rst_tready", vin.tready, 0);
    chk("rst_tvalid", vout.tvalid, 0);
    chk("rst_x", ox, 0);
    chk("rst_y", oy, 0);
    chk("rst_tdata", vout.tdata, 0);
    chk("rst_fc", fc, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("tready_before_edge", vin.tready, 0);
    @(negedge clk);
    chk("tready_after_reset", vin.tready, 1);
    @(posedge clk);
    #1;

    // Junk before SOF is dropped, then a clean frame.
    b_out = n_out;
    for (int i = 0; i < 3; i++) send(PW'($urandom), 1'b0, 1'b0);
    frame(0);
    drain();
    chk("s2_fc", fc, 1);
    chk("s2_beats", n_out - b_out, 8);
    chk("s2_errs", n_early + n_late + n_sof, 0);

    // Clean frame, tready high.
    b_out = n_out;
    frame(0);
    drain();
    chk("s1_fc", fc, 2);
    chk("s1_beats", n_out - b_out, 8);

    // Early end of line on the third beat.
    b_e = n_early;
    send(PW'($urandom), 1'b0, 1'b1);
    send(PW'($urandom), 1'b0, 1'b0);
    send(PW'($urandom), 1'b1, 1'b0);
    for (int c = 0; c < H; c++) send(PW'($urandom), c == H - 1, 1'b0);
    drain();
    chk("early_pulses", n_early - b_e, 1);
    chk("early_fc", fc, 3);

    // tuser mid-line at X=2.
    b_s = n_sof;
    send(PW'($urandom), 1'b0, 1'b1);
    send(PW'($urandom), 1'b0, 1'b0);
    send(PW'($urandom), 1'b0, 1'b1);
    for (int c = 1; c < H; c++) send(PW'($urandom), c == H - 1, 1'b0);
    for (int c = 0; c < H; c++) send(PW'($urandom), c == H - 1, 1'b0);
    drain();
    chk("sof_pulses", n_sof - b_s, 1);
    chk("sof_fc", fc, 4);

    // Line runs two pixels long.
    b_l = n_late;
    b_e = n_early;
    send(PW'($urandom), 1'b0, 1'b1);
    for (int c = 1; c < 6; c++) send(PW'($urandom), c == 5, 1'b0);
    for (int c = 0; c < H; c++) send(PW'($urandom), c == H - 1, 1'b0);
    drain();
    chk("late_pulses", n_late - b_l, 1);
    chk("late_no_early", n_early - b_e, 0);
    chk("late_fc", fc, 5);

    // Downstream stalled: only the skid slot takes one more beat.
    rdy_mode = 2;
    idle(1);
    send(PW'($urandom), 1'b0, 1'b1);
    vin.tdata  = PW'($urandom);
    vin.tlast  = 1'b0;
    vin.tuser  = 1'b0;
    vin.tvalid = 1'b1;
    a0 = n_acc;
    repeat (8) @(negedge clk);
    chk("skid_accepts", n_acc - a0, 1);
    chk("tready_stalled", vin.tready, 0);
    chk("tvalid_stalled", vout.tvalid, 1);
    @(posedge clk);
    #1;
    vin.tvalid = 1'b0;
    rdy_mode = 0;
    idle(3);
    send(PW'($urandom), 1'b0, 1'b0);
    send(PW'($urandom), 1'b1, 1'b0);
    for (int c = 0; c < H; c++) send(PW'($urandom), c == H - 1, 1'b0);
    drain();
    chk("stall_fc", fc, 6);

    // Random back-pressure and input gaps over two frames.
    rdy_mode = 1;
    b_out = n_out;
    b_e = n_early + n_late + n_sof;
    frame(1);
    frame(1);
    drain();
    chk("rand_fc", fc, 8);
    chk("rand_beats", n_out - b_out, 16);
    chk("rand_errs", n_early + n_late + n_sof - b_e, 0);

    // Random sideband traffic against the model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3, 0) == 0) idle(1);
      send(PW'($urandom),
           $urandom_range(3, 0) == 0,
           $urandom_range(7, 0) == 0);
    end
    drain();

    // Reset while the beat at (2,1) sits in the output register.
    rdy_mode = 0;
    send(PW'($urandom), 1'b0, 1'b1);
    for (int c = 1; c < H; c++) send(PW'($urandom), c == H - 1, 1'b0);
    send(PW'($urandom), 1'b0, 1'b0);
    send(PW'($urandom), 1'b0, 1'b0);
    send(PW'($urandom), 1'b0, 1'b0);
    rdy_mode = 2;
    reset = 1'b1;
    @(negedge clk);
    chk("pre_reset_tvalid", vout.tvalid, 1);
    chk("pre_reset_y", oy, 1);
    @(negedge clk);
    chk("post_reset_tvalid", vout.tvalid, 0);
    chk("post_reset_fc", fc, 0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    reset = 1'b0;
    idle(2);
    b_out = n_out;
    frame(0);
    drain();
    chk("after_reset_fc", fc, 1);
    chk("after_reset_beats", n_out - b_out, 8);

    chk("final_queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
